// File: rtl/ifu_pkg.sv
// ifu_pkg: shared types and constants for the instruction fetch unit.
// Holds the FSM state encoding, fault causes, reset PC default and the
// NOP encoding that decode uses when it needs a filler instruction.
package ifu_pkg;

    localparam logic [31:0] RESET_PC_DEF = 32'h8000_0000;
    localparam logic [31:0] INST_NOP     = 32'h0000_0013;
    localparam int unsigned TMO_W        = 8;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_OUT  = 2'd2,
        S_NEXT = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        FC_NONE     = 2'd0,
        FC_RSP_ERR  = 2'd1,
        FC_TIMEOUT  = 2'd2,
        FC_MISALIGN = 2'd3
    } fault_e;

    // Instruction addresses must be 4-byte aligned.
    function automatic logic is_aligned(input logic [1:0] lsb);
        return (lsb == 2'b00);
    endfunction

endpackage

// File: rtl/ifu_fetch_if.sv
// ifu_fetch_if: bundle of the fetch unit's memory, decode and execute
// handshakes. The master modport is the fetch unit; slave is its environment.
interface ifu_fetch_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned INST_W = 32
);
    logic              imem_req_valid;
    logic              imem_req_ready;
    logic [ADDR_W-1:0] imem_req_addr;
    logic              imem_rsp_valid;
    logic [INST_W-1:0] imem_rsp_data;
    logic              imem_rsp_err;
    logic              inst_valid;
    logic              inst_ready;
    logic [INST_W-1:0] inst;
    logic [ADDR_W-1:0] inst_pc;
    logic              inst_err;
    logic              dnpc_valid;
    logic [ADDR_W-1:0] dnpc;

    modport master (
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready,
        input  imem_rsp_valid, imem_rsp_data, imem_rsp_err,
        output inst_valid, inst, inst_pc, inst_err,
        input  inst_ready,
        input  dnpc_valid, dnpc
    );

    modport slave (
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready,
        output imem_rsp_valid, imem_rsp_data, imem_rsp_err,
        input  inst_valid, inst, inst_pc, inst_err,
        output inst_ready,
        output dnpc_valid, dnpc
    );
endinterface

// File: rtl/ifu_fetch_chk.sv
// ifu_fetch_chk: protocol checks on the fetch unit's environment and on
// the consistency between the reported fault flag and its internal cause.
module ifu_fetch_chk
    import ifu_pkg::*;
(
    input logic   clk,
    input logic   rst,
    input state_e i_state,
    input logic   i_stale,
    input logic   i_rsp_valid,
    input logic   i_dnpc_valid,
    input logic   i_inst_valid,
    input logic   i_inst_err,
    input fault_e i_cause
);
    // A response that is not a stale leftover is only legal while waiting.
    a_rsp_in_wait : assert property (@(posedge clk) disable iff (rst)
        (i_rsp_valid && !i_stale) |-> (i_state == S_WAIT))
        else $error("ifu_fetch_chk: imem response outside S_WAIT");

    // Execute may only hand over the next PC once the fetch unit asks for it.
    a_dnpc_in_next : assert property (@(posedge clk) disable iff (rst)
        i_dnpc_valid |-> (i_state == S_NEXT))
        else $error("ifu_fetch_chk: dnpc_valid outside S_NEXT");

    // The error flag seen by decode must agree with the recorded fault cause.
    a_err_cause : assert property (@(posedge clk) disable iff (rst)
        i_inst_valid |-> (i_inst_err == (i_cause != FC_NONE)))
        else $error("ifu_fetch_chk: inst_err disagrees with fault cause");
endmodule

// File: rtl/ifu_perf_cnt.sv
// ifu_perf_cnt: 64-bit fetch and stall event counters, wrapping naturally.
module ifu_perf_cnt (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_fetch_evt,
    input  logic        i_stall_evt,
    output logic [63:0] o_fetch_cnt,
    output logic [63:0] o_stall_cnt
);
    logic [63:0] r_fetch_cnt;
    logic [63:0] r_stall_cnt;

    // Count instruction handshakes and memory-bound stall cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetch_cnt <= 64'd0;
            r_stall_cnt <= 64'd0;
        end else begin
            if (i_fetch_evt) begin
                r_fetch_cnt <= r_fetch_cnt + 64'd1;
            end
            if (i_stall_evt) begin
                r_stall_cnt <= r_stall_cnt + 64'd1;
            end
        end
    end

    assign o_fetch_cnt = r_fetch_cnt;
    assign o_stall_cnt = r_stall_cnt;
endmodule

// File: rtl/ifu_fetch.sv
// ifu_fetch: non-speculative, single-outstanding instruction fetch unit.
// Requests imem at the PC, forwards the instruction to decode, then waits
// for execute to return the next PC. Faults (memory error, response timeout,
// misaligned next PC) are reported through inst_err with inst forced to 0.
// Optional: define IFU_PERF_EN to add 64-bit fetch/stall counter outputs.
module ifu_fetch
    import ifu_pkg::*;
#(
    parameter int unsigned       ADDR_W   = 32,
    parameter int unsigned       INST_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF),
    parameter int unsigned       TIMEOUT  = 255
) (
    input  logic        clk,
    input  logic        rst,
    ifu_fetch_if.master bus
`ifdef IFU_PERF_EN
    ,
    output logic [63:0] perf_fetch_cnt,
    output logic [63:0] perf_stall_cnt
`endif
);
    localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(TIMEOUT);

    state_e            r_state;
    state_e            w_state_nxt;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] w_pc_nxt;
    logic [INST_W-1:0] r_inst;
    logic [INST_W-1:0] w_inst_nxt;
    logic              r_err;
    logic              w_err_nxt;
    logic              r_inst_valid;
    logic              w_inst_valid_nxt;
    logic              r_req_valid;
    logic              w_req_valid_nxt;
    logic              r_stale;
    logic              w_stale_nxt;
    logic [TMO_W-1:0]  r_tmo_cnt;
    logic [TMO_W-1:0]  w_tmo_cnt_nxt;
    fault_e            r_cause;
    fault_e            w_cause_nxt;

    logic w_req_hs;
    logic w_inst_hs;
    logic w_rsp_take;
    logic w_rsp_stale;
    logic w_tmo_hit;
    logic w_dnpc_take;
    logic w_dnpc_ok;

    assign w_req_hs    = r_req_valid & bus.imem_req_ready;
    assign w_inst_hs   = r_inst_valid & bus.inst_ready;
    assign w_rsp_stale = bus.imem_rsp_valid & r_stale;
    assign w_rsp_take  = bus.imem_rsp_valid & ~r_stale & (r_state == S_WAIT);
    // A response arriving on the timeout cycle wins over the fault.
    assign w_tmo_hit   = (r_state == S_WAIT) & ~bus.imem_rsp_valid & (r_tmo_cnt == TMO_MAX);
    assign w_dnpc_take = (r_state == S_NEXT) & bus.dnpc_valid;
    assign w_dnpc_ok   = is_aligned(bus.dnpc[1:0]);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_REQ;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state selection.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_REQ: begin
                if (w_req_hs) w_state_nxt = S_WAIT;
                else          w_state_nxt = S_REQ;
            end
            S_WAIT: begin
                if (w_rsp_take || w_tmo_hit) w_state_nxt = S_OUT;
                else                         w_state_nxt = S_WAIT;
            end
            S_OUT: begin
                if (w_inst_hs) w_state_nxt = S_NEXT;
                else           w_state_nxt = S_OUT;
            end
            S_NEXT: begin
                if (w_dnpc_take) w_state_nxt = w_dnpc_ok ? S_REQ : S_OUT;
                else             w_state_nxt = S_NEXT;
            end
            default: w_state_nxt = S_REQ;
        endcase
    end

    // Next values of the registered outputs, PC, timeout counter and stale flag.
    always_comb begin
        w_pc_nxt      = r_pc;
        w_inst_nxt    = r_inst;
        w_err_nxt     = r_err;
        w_cause_nxt   = r_cause;
        w_tmo_cnt_nxt = r_tmo_cnt;
        w_stale_nxt   = r_stale;

        // A timed-out request leaves one response owed by memory; swallow it.
        if (w_tmo_hit) begin
            w_stale_nxt = 1'b1;
        end else if (w_rsp_stale) begin
            w_stale_nxt = 1'b0;
        end else begin
            w_stale_nxt = r_stale;
        end

        if (w_req_hs) begin
            w_tmo_cnt_nxt = {TMO_W{1'b0}};
        end else if ((r_state == S_WAIT) && !w_rsp_take && !w_tmo_hit) begin
            w_tmo_cnt_nxt = r_tmo_cnt + {{(TMO_W-1){1'b0}}, 1'b1};
        end else begin
            w_tmo_cnt_nxt = r_tmo_cnt;
        end

        if (w_rsp_take) begin
            w_inst_nxt  = bus.imem_rsp_data;
            w_err_nxt   = bus.imem_rsp_err;
            w_cause_nxt = bus.imem_rsp_err ? FC_RSP_ERR : FC_NONE;
        end else if (w_tmo_hit) begin
            w_inst_nxt  = {INST_W{1'b0}};
            w_err_nxt   = 1'b1;
            w_cause_nxt = FC_TIMEOUT;
        end else if (w_dnpc_take && !w_dnpc_ok) begin
            w_inst_nxt  = {INST_W{1'b0}};
            w_err_nxt   = 1'b1;
            w_cause_nxt = FC_MISALIGN;
        end else begin
            w_inst_nxt  = r_inst;
            w_err_nxt   = r_err;
            w_cause_nxt = r_cause;
        end

        if (w_dnpc_take) begin
            w_pc_nxt = bus.dnpc;
        end else begin
            w_pc_nxt = r_pc;
        end

        // Valids are registered from the next state so they line up with it.
        w_req_valid_nxt  = (w_state_nxt == S_REQ) & ~w_stale_nxt;
        w_inst_valid_nxt = (w_state_nxt == S_OUT);
    end

    // Datapath and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc         <= RESET_PC;
            r_inst       <= {INST_W{1'b0}};
            r_err        <= 1'b0;
            r_cause      <= FC_NONE;
            r_tmo_cnt    <= {TMO_W{1'b0}};
            r_stale      <= 1'b0;
            r_req_valid  <= 1'b0;
            r_inst_valid <= 1'b0;
        end else begin
            r_pc         <= w_pc_nxt;
            r_inst       <= w_inst_nxt;
            r_err        <= w_err_nxt;
            r_cause      <= w_cause_nxt;
            r_tmo_cnt    <= w_tmo_cnt_nxt;
            r_stale      <= w_stale_nxt;
            r_req_valid  <= w_req_valid_nxt;
            r_inst_valid <= w_inst_valid_nxt;
        end
    end

    assign bus.imem_req_valid = r_req_valid;
    assign bus.imem_req_addr  = r_pc;
    assign bus.inst_valid     = r_inst_valid;
    assign bus.inst           = r_inst;
    assign bus.inst_pc        = r_pc;
    assign bus.inst_err       = r_err;

`ifdef IFU_PERF_EN
    logic w_stall_evt;
    assign w_stall_evt = (r_state == S_REQ) | (r_state == S_WAIT);

    ifu_perf_cnt u_perf (
        .clk         (clk),
        .rst         (rst),
        .i_fetch_evt (w_inst_hs),
        .i_stall_evt (w_stall_evt),
        .o_fetch_cnt (perf_fetch_cnt),
        .o_stall_cnt (perf_stall_cnt)
    );
`else
    // Without IFU_PERF_EN no event counters are built.
`endif

    ifu_fetch_chk u_chk (
        .clk          (clk),
        .rst          (rst),
        .i_state      (r_state),
        .i_stale      (r_stale),
        .i_rsp_valid  (bus.imem_rsp_valid),
        .i_dnpc_valid (bus.dnpc_valid),
        .i_inst_valid (r_inst_valid),
        .i_inst_err   (r_err),
        .i_cause      (r_cause)
    );
endmodule

// File: tb/tb_ifu_fetch.sv
// tb_ifu_fetch: directed bench for ifu_fetch. A transaction-level model
// predicts the ordered imem request addresses and decode-side instructions;
// a negedge monitor compares every meaningful cycle against it. The driver
// walks a table of PCs with per-entry memory/decode timing knobs.
module tb_ifu_fetch;
    localparam int NV      = 9;
    localparam int TIMEOUT = 255;

    typedef struct {
        logic [31:0] pc;
        int          req_stall;
        int          rsp_lat;
        int          rdy_stall;
        bit          err;
        bit          nores;
    } vec_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        err;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   n_inst = 0;
    int   n_req = 0;
    int   exp_req_cnt = 0;

    vec_t        vecs[NV];
    exp_t        exp_q[$];
    logic [31:0] req_q[$];

    ifu_fetch_if #(.ADDR_W(32), .INST_W(32)) bus ();

`ifdef IFU_PERF_EN
    logic [63:0] perf_fetch_cnt;
    logic [63:0] perf_stall_cnt;
`endif

    ifu_fetch #(.ADDR_W(32), .INST_W(32), .RESET_PC(32'h8000_0000), .TIMEOUT(TIMEOUT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef IFU_PERF_EN
        ,
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_stall_cnt (perf_stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], 16'h0513};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Compare process: every cycle the DUT presents something, it must be the model's head item.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.inst_valid) begin
                if (exp_q.size() == 0) begin
                    check("inst_unexpected", 64'(bus.inst_valid), 64'd0);
                end else begin
                    check("inst_pc", 64'(bus.inst_pc), 64'(exp_q[0].pc));
                    check("inst_data", 64'(bus.inst), 64'(exp_q[0].inst));
                    check("inst_err", 64'(bus.inst_err), 64'(exp_q[0].err));
                    if (bus.inst_ready) begin
                        void'(exp_q.pop_front());
                        n_inst++;
                    end
                end
            end
            if (bus.imem_req_valid) begin
                if (req_q.size() == 0) begin
                    check("req_unexpected", 64'(bus.imem_req_valid), 64'd0);
                end else begin
                    check("req_addr", 64'(bus.imem_req_addr), 64'(req_q[0]));
                    if (bus.imem_req_ready) begin
                        void'(req_q.pop_front());
                        n_req++;
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        v;
        int          n;
        int          t_dnpc;
        int          t_hs;
        int          n_req_before;
        bit          pend_late;
        exp_t        e;

        //             pc            rqs rsl rdy err nores
        vecs[0] = '{32'h8000_0000, 0, 0, 5, 1'b0, 1'b0};
        vecs[1] = '{32'h8000_0004, 0, 0, 0, 1'b0, 1'b0};
        vecs[2] = '{32'h8000_0008, 3, 2, 1, 1'b0, 1'b0};
        vecs[3] = '{32'h8000_0010, 0, 1, 0, 1'b1, 1'b0};
        vecs[4] = '{32'h8000_0100, 1, 0, 2, 1'b0, 1'b0};
        vecs[5] = '{32'h8000_0200, 0, 0, 0, 1'b0, 1'b1};
        vecs[6] = '{32'h8000_0204, 0, 3, 0, 1'b0, 1'b0};
        vecs[7] = '{32'h8000_0006, 0, 0, 2, 1'b0, 1'b0};
        vecs[8] = '{32'h8000_0300, 2, 1, 0, 1'b0, 1'b0};

        // Model: what decode and memory must see, straight from the fetch rules.
        for (int i = 0; i < NV; i++) begin
            e.pc = vecs[i].pc;
            if (vecs[i].pc[1:0] != 2'b00) begin
                e.inst = 32'h0;
                e.err  = 1'b1;
            end else begin
                req_q.push_back(vecs[i].pc);
                exp_req_cnt++;
                if (vecs[i].nores) begin
                    e.inst = 32'h0;
                    e.err  = 1'b1;
                end else begin
                    e.inst = mem_word(vecs[i].pc);
                    e.err  = vecs[i].err;
                end
            end
            exp_q.push_back(e);
        end

        bus.imem_req_ready = 1'b0;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = 32'h0;
        bus.imem_rsp_err   = 1'b0;
        bus.inst_ready     = 1'b0;
        bus.dnpc_valid     = 1'b0;
        bus.dnpc           = 32'h0;
        pend_late          = 1'b0;
        t_dnpc             = 0;
        t_hs               = 0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_req_valid", 64'(bus.imem_req_valid), 64'd0);
        check("rst_inst_valid", 64'(bus.inst_valid), 64'd0);
        check("rst_inst", 64'(bus.inst), 64'd0);
        check("rst_inst_err", 64'(bus.inst_err), 64'd0);
        check("rst_pc", 64'(bus.imem_req_addr), 64'h8000_0000);
        rst = 1'b0;
        step();
        check("req_1cyc_after_rst", 64'(bus.imem_req_valid), 64'd1);

        for (int i = 0; i < NV; i++) begin
            v = vecs[i];
            n_req_before = n_req;
            if (i > 0) begin
                bus.dnpc_valid = 1'b1;
                bus.dnpc       = v.pc;
                t_dnpc         = cyc;
                step();
                bus.dnpc_valid = 1'b0;
            end
            if (v.pc[1:0] == 2'b00) begin
                if (pend_late) begin
                    for (int k = 0; k < 4; k++) begin
                        check("stale_no_req", 64'(bus.imem_req_valid), 64'd0);
                        step();
                    end
                    bus.imem_rsp_valid = 1'b1;
                    bus.imem_rsp_data  = 32'hDEAD_BEEF;
                    step();
                    bus.imem_rsp_valid = 1'b0;
                    check("req_after_discard", 64'(bus.imem_req_valid), 64'd1);
                    pend_late = 1'b0;
                end
                n = 0;
                while (!bus.imem_req_valid && n < 50) begin
                    step();
                    n++;
                end
                check("req_seen", 64'(bus.imem_req_valid), 64'd1);
                repeat (v.req_stall) step();
                bus.imem_req_ready = 1'b1;
                step();
                bus.imem_req_ready = 1'b0;
                t_hs = cyc;
                if (!v.nores) begin
                    repeat (v.rsp_lat) step();
                    bus.imem_rsp_valid = 1'b1;
                    bus.imem_rsp_data  = mem_word(v.pc);
                    bus.imem_rsp_err   = v.err;
                    step();
                    bus.imem_rsp_valid = 1'b0;
                    bus.imem_rsp_err   = 1'b0;
                end else begin
                    pend_late = 1'b1;
                end
            end
            n = 0;
            while (!bus.inst_valid && n < 300) begin
                step();
                n++;
            end
            check("inst_valid_seen", 64'(bus.inst_valid), 64'd1);
            if (v.pc[1:0] == 2'b00 && !v.nores) check("rsp_to_inst_1cyc", 64'(n), 64'd0);
            if (i == 0) begin
                check("first_inst", 64'(bus.inst), 64'h0000_0513);
                check("first_pc", 64'(bus.inst_pc), 64'h8000_0000);
                check("first_err", 64'(bus.inst_err), 64'd0);
            end
            if (i == 1) check("dnpc_to_inst_lat", 64'(cyc - t_dnpc), 64'd3);
            if (i == 3) begin
                check("rsperr_err", 64'(bus.inst_err), 64'd1);
                check("rsperr_pc", 64'(bus.inst_pc), 64'h8000_0010);
            end
            if (v.nores) begin
                check("timeout_lat", 64'(cyc - t_hs), 64'(TIMEOUT + 1));
                check("timeout_inst", 64'(bus.inst), 64'd0);
                check("timeout_err", 64'(bus.inst_err), 64'd1);
            end
            if (v.pc[1:0] != 2'b00) begin
                check("misalign_no_req", 64'(n_req), 64'(n_req_before));
                check("misalign_pc", 64'(bus.inst_pc), 64'h8000_0006);
                check("misalign_err", 64'(bus.inst_err), 64'd1);
            end
            for (int k = 0; k < v.rdy_stall; k++) begin
                check("decode_stall_no_req", 64'(bus.imem_req_valid), 64'd0);
                step();
            end
            bus.inst_ready = 1'b1;
            step();
            bus.inst_ready = 1'b0;
        end

        repeat (3) step();
        check("all_inst_consumed", 64'(exp_q.size()), 64'd0);
        check("all_req_consumed", 64'(req_q.size()), 64'd0);
        check("inst_handshakes", 64'(n_inst), 64'(NV));
        check("req_handshakes", 64'(n_req), 64'(exp_req_cnt));
        check("req_handshakes_lit", 64'(n_req), 64'd8);
`ifdef IFU_PERF_EN
        check("perf_fetch_cnt", perf_fetch_cnt, 64'(n_inst));
        check("perf_stall_min", 64'(perf_stall_cnt >= 64'd256), 64'd1);
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
